// File: rtl/vec_pipe_pkg.sv
// Shared definitions for the vector pipeline stage registers.
package vec_pipe_pkg;

  localparam int LANES_DEF  = 4;
  localparam int LANE_W_DEF = 16;
  localparam int DATA_W_DEF = LANES_DEF * LANE_W_DEF;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Lane-wise merge for the default vector geometry: enabled lanes take the
  // new data, the rest keep the hold value.
  function automatic logic [DATA_W_DEF-1:0] lane_merge(
    input logic [DATA_W_DEF-1:0] data,
    input logic [LANES_DEF-1:0]  mask,
    input logic [DATA_W_DEF-1:0] hold
  );
    logic [DATA_W_DEF-1:0] res;
    res = hold;
    for (int i = 0; i < LANES_DEF; i++) begin
      if (mask[i]) res[i*LANE_W_DEF +: LANE_W_DEF] = data[i*LANE_W_DEF +: LANE_W_DEF];
    end
    return res;
  endfunction

endpackage

// File: rtl/vec_pipe_reg_entry.sv
// One storage slot (payload + mask) with a valid bit, updated on the falling edge.
module pipe_entry_reg #(
  parameter int W = 68
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Clearing only drops the valid bit; the payload is left as-is.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/vec_pipe_reg.sv
// Elastic valid/ready vector pipeline stage with a two-entry skid buffer,
// per-lane write mask merged against a hold register, and synchronous flush.
//
// state     | meaning
// OCC_EMPTY | no beat stored, main and skid invalid
// OCC_ONE   | main holds the head beat, skid empty
// OCC_FULL  | main holds head, skid holds next beat, upstream stalled
module vec_pipe_reg
  import vec_pipe_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int DATA_W = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LANES-1:0]  in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LANES-1:0]  out_mask,
  output logic [1:0]        count
);

  localparam int ENT_W = DATA_W + LANES;

  occ_e              state;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] merged;
  logic [ENT_W-1:0]  main_q, skid_q, main_d;
  logic              main_valid, skid_valid;
  logic              main_load, main_clr, skid_load, skid_clr;
  logic              accept, emit;

  assign in_ready = ~skid_valid & ~flush;
  assign accept   = in_valid & in_ready;
  assign emit     = main_valid & out_ready;

  // Lane merge of the incoming beat against the hold register.
  always_comb begin
    merged = hold_q;
    for (int i = 0; i < LANES; i++) begin
      if (in_mask[i]) merged[i*LANE_W +: LANE_W] = in_data[i*LANE_W +: LANE_W];
    end
  end

  // Entry control: main refills from skid when full, otherwise from the input.
  always_comb begin
    main_d    = (state == OCC_FULL) ? skid_q : {in_mask, merged};
    main_load = ~flush & ((accept & ((state == OCC_EMPTY) | ((state == OCC_ONE) & emit)))
                          | ((state == OCC_FULL) & emit));
    main_clr  = flush | ((state == OCC_ONE) & emit & ~accept);
    skid_load = ~flush & (state == OCC_ONE) & accept & ~emit;
    skid_clr  = flush | ((state == OCC_FULL) & emit);
  end

  pipe_entry_reg #(.W(ENT_W)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_load),
    .clr     (main_clr),
    .d       (main_d),
    .q       (main_q),
    .valid   (main_valid)
  );

  pipe_entry_reg #(.W(ENT_W)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .clr     (skid_clr),
    .d       ({in_mask, merged}),
    .q       (skid_q),
    .valid   (skid_valid)
  );

  // Hold register tracks the last accepted merged beat; survives flush.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n)    hold_q <= '0;
    else if (accept) hold_q <= merged;
  end

  // Occupancy FSM with registered count.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= OCC_EMPTY;
      count <= 2'd0;
    end else if (flush) begin
      state <= OCC_EMPTY;
      count <= 2'd0;
    end else begin
      case (state)
        OCC_EMPTY: if (accept) begin
          state <= OCC_ONE;
          count <= 2'd1;
        end
        OCC_ONE: if (accept & ~emit) begin
          state <= OCC_FULL;
          count <= 2'd2;
        end else if (~accept & emit) begin
          state <= OCC_EMPTY;
          count <= 2'd0;
        end
        OCC_FULL: if (emit) begin
          state <= OCC_ONE;
          count <= 2'd1;
        end
        default: begin
          state <= OCC_EMPTY;
          count <= 2'd0;
        end
      endcase
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_q[DATA_W-1:0];
  assign out_mask  = main_q[ENT_W-1:DATA_W];

endmodule

// File: tb/tb_vec_pipe_reg.sv
// Directed bench for vec_pipe_reg with a queue-based scoreboard.
module tb_vec_pipe_reg;

  logic        clk, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [3:0]  in_mask, out_mask;
  logic [1:0]  count;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  m;
  } beat_t;

  beat_t       sb[$];
  logic [63:0] hold_m;
  int          checks = 0;
  int          errors = 0;

  vec_pipe_reg dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .count     (count)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge_m(input logic [63:0] d, input logic [3:0] m,
                                          input logic [63:0] h);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = m[i] ? d[i*16 +: 16] : h[i*16 +: 16];
    return r;
  endfunction

  // Predict the handshakes for the coming falling edge, advance the model,
  // then check the DUT just after the edge.
  task automatic cycle();
    beat_t b;
    logic  exp_rdy;
    #1;
    exp_rdy = (sb.size() < 2) && !flush;
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    if (flush) begin
      sb.delete();
    end else begin
      if (sb.size() != 0 && out_ready) begin
        chk("emit_data", out_data, sb[0].d);
        void'(sb.pop_front());
      end
      if (in_valid && exp_rdy) begin
        b.d    = merge_m(in_data, in_mask, hold_m);
        b.m    = in_mask;
        hold_m = b.d;
        sb.push_back(b);
      end
    end
    @(negedge clk);
    #1;
    chk("count", {62'd0, count}, 64'(sb.size()));
    chk("out_valid", {63'd0, out_valid}, {63'd0, (sb.size() != 0)});
    if (sb.size() != 0) begin
      chk("out_data", out_data, sb[0].d);
      chk("out_mask", {60'd0, out_mask}, {60'd0, sb[0].m});
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [3:0] m,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_mask   = m;
    out_ready = ordy;
    flush     = fl;
    cycle();
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mask = '0;
    out_ready = 1'b0; hold_m = '0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_count", {62'd0, count}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    #1 reset_n = 1'b1;

    // streaming, no bubbles
    drive(1'b1, 64'h0001_0002_0003_0004, 4'hF, 1'b1, 1'b0);
    chk("stream0", out_data, 64'h0001_0002_0003_0004);
    drive(1'b1, 64'h0005_0006_0007_0008, 4'hF, 1'b1, 1'b0);
    chk("stream1", out_data, 64'h0005_0006_0007_0008);
    drive(1'b1, 64'h0009_000A_000B_000C, 4'hF, 1'b1, 1'b0);
    chk("stream2", out_data, 64'h0009_000A_000B_000C);
    chk("stream_cnt", {62'd0, count}, 64'd1);
    drive(1'b0, 64'd0, 4'h0, 1'b1, 1'b0);

    // backpressure
    drive(1'b1, 64'hAAAA_0000_0000_0001, 4'hF, 1'b0, 1'b0);
    drive(1'b1, 64'hBBBB_0000_0000_0002, 4'hF, 1'b0, 1'b0);
    chk("bp_full_cnt", {62'd0, count}, 64'd2);
    drive(1'b1, 64'hCCCC_0000_0000_0003, 4'hF, 1'b0, 1'b0);
    drive(1'b1, 64'hCCCC_0000_0000_0003, 4'hF, 1'b1, 1'b0);
    chk("bp_second", out_data, 64'hBBBB_0000_0000_0002);
    drive(1'b1, 64'hCCCC_0000_0000_0003, 4'hF, 1'b1, 1'b0);
    chk("bp_third", out_data, 64'hCCCC_0000_0000_0003);
    drive(1'b0, 64'd0, 4'h0, 1'b1, 1'b0);

    // lane mask
    drive(1'b1, 64'h0004_0003_0002_0001, 4'hF, 1'b1, 1'b0);
    drive(1'b1, 64'h0008_0007_0006_0005, 4'h5, 1'b1, 1'b0);
    chk("mask_merge", out_data, 64'h0004_0007_0002_0005);
    chk("mask_pass", {60'd0, out_mask}, 64'h5);
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 1'b1, 1'b0);
    chk("mask_zero", out_data, 64'h0004_0007_0002_0005);
    drive(1'b0, 64'd0, 4'h0, 1'b1, 1'b0);

    // flush with a full stage and a beat presented
    drive(1'b1, 64'h00AA_00BB_00CC_00DD, 4'hF, 1'b0, 1'b0);
    drive(1'b1, 64'h0011_0022_0033_0044, 4'hF, 1'b0, 1'b0);
    drive(1'b1, 64'h5555_6666_7777_8888, 4'hF, 1'b1, 1'b1);
    chk("flush_cnt", {62'd0, count}, 64'd0);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h1, 1'b1, 1'b0);
    chk("flush_hold", out_data, 64'h0011_0022_0033_FFFF);
    drive(1'b0, 64'd0, 4'h0, 1'b1, 1'b0);

    // continuous valid, toggling out_ready
    for (int i = 0; i < 8; i++) drive(1'b1, 64'(i + 64'h100), 4'hF, (i % 2) == 0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 64'd0, 4'h0, 1'b1, 1'b0);

    // asynchronous reset mid-transfer
    drive(1'b1, 64'h1111_1111_1111_1111, 4'hF, 1'b0, 1'b0);
    drive(1'b1, 64'h2222_2222_2222_2222, 4'hF, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_data", out_data, 64'd0);
    chk("arst_count", {62'd0, count}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    sb.delete();
    hold_m = '0;
    #1 reset_n = 1'b1;
    @(negedge clk);
    #1;
    drive(1'b1, 64'h1234_5678_9ABC_DEF0, 4'h1, 1'b1, 1'b0);
    chk("arst_first", out_data, 64'h0000_0000_0000_DEF0);
    chk("arst_first_v", {63'd0, out_valid}, 64'd1);
    drive(1'b0, 64'd0, 4'h0, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 4'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
